// File: rtl/somador_pkg.sv
// somador_pkg
//   Shared types and helpers for the digit-serial adder/subtractor.
//   estado_t : controller states (OCIOSO, SOMANDO, FIM)
//   clog2    : counter width helper, never returns less than 1 bit
package somador_pkg;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      SOMANDO = 2'd1,
      FIM     = 2'd2
   } estado_t;

   // Minimum of 1 so a single-step configuration still gets a legal counter.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/somador_digito.sv
// somador_digito
//   Purely combinational DIGIT-bit ripple adder built from chained full-adder
//   cells; one instance is reused every cycle by the serial adder.
//   a, b   : in  DIGIT  operand digits
//   ci     : in  1      carry into bit 0
//   s      : out DIGIT  sum digit
//   co     : out 1      carry out of the MSB
//   msb_ci : out 1      carry into the MSB (signed-overflow detection)
module somador_digito #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             msb_ci
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co     = c[DIGIT];
   assign msb_ci = c[DIGIT-1];

endmodule

// File: rtl/somador_serial_param.sv
// somador_serial_param
//   Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
//   clock through one somador_digito slice, carry held in a flop between slices.
//   Optional feature macro: SOMADOR_OVF_EN (adds the signed-overflow output ovf).
//   clk, rst       : clock (rising edge), async active-high reset
//   inicio         : start request, honoured only when idle
//   X, Y, TE, sub  : operands, carry-in, subtract select (captured on start)
//   ocupado        : high while slices are being processed
//   pronto         : one-cycle pulse, result valid
//   resultadoSoma  : {TS, S}, held until the next completion
//   TS             : carry-out (subtract: 1 = no borrow)
//   ovf            : signed overflow (SOMADOR_OVF_EN only)
//
// state   | meaning
// OCIOSO  | idle, waiting for inicio
// SOMANDO | one DIGIT slice per cycle, STEPS cycles
// FIM     | result registered, pronto high for this cycle
module somador_serial_param
   import somador_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inicio,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             TE,
   input  logic             sub,
   output logic             ocupado,
   output logic             pronto,
   output logic [WIDTH:0]   resultadoSoma,
   output logic             TS
`ifdef SOMADOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = clog2(STEPS);

   if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
      $error("somador_serial_param: DIGIT must be in 1..WIDTH");
   end
   if (WIDTH % DIGIT != 0) begin : g_bad_width
      $error("somador_serial_param: WIDTH must be a multiple of DIGIT");
   end

   estado_t          state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   res_q, res_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT-1:0]       slice_s;
   logic                   slice_co;
   logic                   slice_msb_ci;
   logic [WIDTH+DIGIT-1:0] acc_sh;

   somador_digito #(.DIGIT(DIGIT)) u_digito (
      .a      (opa_q[DIGIT-1:0]),
      .b      (opb_q[DIGIT-1:0]),
      .ci     (carry_q),
      .s      (slice_s),
      .co     (slice_co),
      .msb_ci (slice_msb_ci)
   );

   // New digit enters at the MSB end; after STEPS shifts the first digit sits at bit 0.
   assign acc_sh = {slice_s, acc_q} >> DIGIT;

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      case (state_q)
         OCIOSO: begin
            if (inicio) begin
               opa_d   = X;
               opb_d   = sub ? ~Y : Y;
               carry_d = sub ? 1'b1 : TE;
               cnt_d   = CW'(STEPS - 1);
               state_d = SOMANDO;
            end
         end
         SOMANDO: begin
            opa_d   = opa_q >> DIGIT;
            opb_d   = opb_q >> DIGIT;
            acc_d   = acc_sh[WIDTH-1:0];
            carry_d = slice_co;
            if (cnt_q == '0) begin
               // Register the result on the last slice so it is valid throughout FIM.
               res_d   = {slice_co, acc_sh[WIDTH-1:0]};
               ovf_d   = slice_msb_ci ^ slice_co;
               state_d = FIM;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         FIM: begin
            state_d = OCIOSO;
         end
         default: begin
            state_d = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= OCIOSO;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ocupado       = (state_q == SOMANDO);
   assign pronto        = (state_q == FIM);
   assign resultadoSoma = res_q;
   assign TS            = res_q[WIDTH];

`ifdef SOMADOR_OVF_EN
   assign ovf = ovf_q;
`else
   logic ovf_unused;
   assign ovf_unused = ovf_q ^ slice_msb_ci;
`endif

endmodule

// File: tb/tb_somador_serial_param.sv
module tb_somador_serial_param;

   logic        clk, rst, inicio, TE, sub;
   logic [15:0] X, Y;

   logic        ocupado_1, ocupado_4, ocupado_16;
   logic        pronto_1, pronto_4, pronto_16;
   logic [16:0] res_1, res_4, res_16;
   logic        ts_1, ts_4, ts_16;
`ifdef SOMADOR_OVF_EN
   logic        ovf_1, ovf_4, ovf_16;
`endif

   somador_serial_param #(.WIDTH(16), .DIGIT(4)) dut4 (
      .clk(clk), .rst(rst), .inicio(inicio), .X(X), .Y(Y), .TE(TE), .sub(sub),
      .ocupado(ocupado_4), .pronto(pronto_4), .resultadoSoma(res_4), .TS(ts_4)
`ifdef SOMADOR_OVF_EN
      , .ovf(ovf_4)
`endif
   );

   somador_serial_param #(.WIDTH(16), .DIGIT(1)) dut1 (
      .clk(clk), .rst(rst), .inicio(inicio), .X(X), .Y(Y), .TE(TE), .sub(sub),
      .ocupado(ocupado_1), .pronto(pronto_1), .resultadoSoma(res_1), .TS(ts_1)
`ifdef SOMADOR_OVF_EN
      , .ovf(ovf_1)
`endif
   );

   somador_serial_param #(.WIDTH(16), .DIGIT(16)) dut16 (
      .clk(clk), .rst(rst), .inicio(inicio), .X(X), .Y(Y), .TE(TE), .sub(sub),
      .ocupado(ocupado_16), .pronto(pronto_16), .resultadoSoma(res_16), .TS(ts_16)
`ifdef SOMADOR_OVF_EN
      , .ovf(ovf_16)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [16:0] res;
      logic        ovf;
   } sb_item_t;

   sb_item_t sb_q[$];
   sb_item_t e_mon;

   typedef struct {
      logic [15:0] x, y;
      logic        te, s;
      logic [16:0] res;
      logic        ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [16:0] model_res(input logic [15:0] x, input logic [15:0] y,
                                             input logic te, input logic s);
      if (s) return {1'b0, x} + {1'b0, ~y} + 17'd1;
      return {1'b0, x} + {1'b0, y} + {16'd0, te};
   endfunction

   function automatic logic model_ovf(input logic [15:0] x, input logic [15:0] y,
                                      input logic te, input logic s);
      logic [16:0] r;
      r = model_res(x, y, te, s);
      if (s) return (x[15] != y[15]) && (r[15] != x[15]);
      return (x[15] == y[15]) && (r[15] != x[15]);
   endfunction

   // Scoreboard for the DIGIT=4 instance: every pronto pops one expectation.
   always @(negedge clk) begin
      if (pronto_4) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_pronto", {31'd0, pronto_4}, 32'd0);
         end else begin
            e_mon = sb_q.pop_front();
            chk("result", {15'd0, res_4}, {15'd0, e_mon.res});
            chk("ts", {31'd0, ts_4}, {31'd0, e_mon.res[16]});
`ifdef SOMADOR_OVF_EN
            chk("ovf", {31'd0, ovf_4}, {31'd0, e_mon.ovf});
`endif
         end
      end
   end

   // Present operands for one cycle, then scramble the inputs so any late sampling shows up.
   task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic te,
                           input logic s, input logic push, input logic [16:0] er,
                           input logic eo);
      @(negedge clk);
      X = x; Y = y; TE = te; sub = s; inicio = 1'b1;
      if (push) sb_q.push_back('{res: er, ovf: eo});
      @(negedge clk);
      inicio = 1'b0;
      X = ~x; Y = y ^ 16'h5A5A; TE = ~te; sub = ~s;
   endtask

   // Called at the negedge of cycle cyc0 after acceptance; returns one cycle after FIM.
   task automatic wait_done(input string nm, input int cyc0, input int exp_lat,
                            input logic inject);
      int cyc, occ;
      cyc = cyc0;
      occ = ocupado_4 ? 1 : 0;
      while (!pronto_4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (ocupado_4) occ++;
      end
      chk({nm, "_latency"}, cyc, exp_lat);
      chk({nm, "_ocupado_cycles"}, occ, exp_lat - cyc0);
      chk({nm, "_ocupado_in_fim"}, {31'd0, ocupado_4}, 32'd0);
      if (inject) inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      chk({nm, "_pronto_one_cycle"}, {31'd0, pronto_4}, 32'd0);
      chk({nm, "_ignored_in_fim"}, {31'd0, ocupado_4}, 32'd0);
   endtask

   initial begin
      int l1, l4, l16, np;
      logic [15:0] rx, ry;
      logic rte, rs;
      logic [16:0] er;

      vecs[0] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 17'h02346, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0};
      vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1};
      vecs[4] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 17'h00002, 1'b0};
      vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1};
      vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1};
      vecs[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 17'h10000, 1'b0};
      vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, 1'b0};

      rst = 1'b1; inicio = 1'b0; X = '0; Y = '0; TE = 1'b0; sub = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_result", {15'd0, res_4}, 32'd0);
      chk("reset_ts", {31'd0, ts_4}, 32'd0);
      chk("reset_ocupado", {31'd0, ocupado_4}, 32'd0);
      chk("reset_pronto", {31'd0, pronto_4}, 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         start_op(vecs[i].x, vecs[i].y, vecs[i].te, vecs[i].s, 1'b1, vecs[i].res, vecs[i].ovf);
         wait_done($sformatf("vec%0d", i), 1, 5, (i % 2) == 1);
      end

      // Second inicio during SOMANDO must be dropped, not queued.
      start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1, 17'h0FFFF, 1'b0);
      @(negedge clk);
      X = 16'h0001; Y = 16'h0001; inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      wait_done("busy_inicio", 3, 5, 1'b0);
      repeat (3) @(negedge clk);
      chk("busy_inicio_not_queued", {31'd0, ocupado_4}, 32'd0);

      // Reset in the middle of an operation: aborts and clears the held result.
      start_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 17'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_result", {15'd0, res_4}, 32'd0);
      chk("abort_ts", {31'd0, ts_4}, 32'd0);
      chk("abort_ocupado", {31'd0, ocupado_4}, 32'd0);
      chk("abort_pronto", {31'd0, pronto_4}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      np = 0;
      repeat (20) begin
         @(negedge clk);
         if (pronto_4 || pronto_1 || pronto_16) np++;
      end
      chk("abort_no_pronto", np, 0);

      // DIGIT sweep against the reference model.
      for (int k = 0; k < 8; k++) begin
         rx  = 16'($urandom_range(0, 65535));
         ry  = 16'($urandom_range(0, 65535));
         rte = 1'($urandom_range(0, 1));
         rs  = 1'($urandom_range(0, 1));
         if (k == 0) begin rx = 16'hFFFF; ry = 16'h0001; rte = 1'b0; rs = 1'b0; end
         er = model_res(rx, ry, rte, rs);
         start_op(rx, ry, rte, rs, 1'b1, er, model_ovf(rx, ry, rte, rs));
         l1 = 0; l4 = 0; l16 = 0;
         for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            if (pronto_4 && l4 == 0) l4 = c;
            if (pronto_1 && l1 == 0) begin
               l1 = c;
               chk("d1_result", {15'd0, res_1}, {15'd0, er});
               chk("d1_ts", {31'd0, ts_1}, {31'd0, er[16]});
               chk("d1_ocupado_in_fim", {31'd0, ocupado_1}, 32'd0);
`ifdef SOMADOR_OVF_EN
               chk("d1_ovf", {31'd0, ovf_1}, {31'd0, model_ovf(rx, ry, rte, rs)});
`endif
            end
            if (pronto_16 && l16 == 0) begin
               l16 = c;
               chk("d16_result", {15'd0, res_16}, {15'd0, er});
               chk("d16_ts", {31'd0, ts_16}, {31'd0, er[16]});
               chk("d16_ocupado_in_fim", {31'd0, ocupado_16}, 32'd0);
`ifdef SOMADOR_OVF_EN
               chk("d16_ovf", {31'd0, ovf_16}, {31'd0, model_ovf(rx, ry, rte, rs)});
`endif
            end
         end
         chk("d1_latency", l1, 17);
         chk("d4_latency", l4, 5);
         chk("d16_latency", l16, 2);
      end

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
